alu_exec_seq: RTL and testbench

- Parametrised successor to the combinational ALU control decoder.
- Decodes AluOp/funct into the 4-bit ALU control code and also executes the operation.
- Single-cycle ops finish in 1 cycle; shifts run one bit per cycle; optional shift-add multiply.
- Sits in the EX stage between decode and writeback, using a valid/ready handshake on both sides.

---
 rtl/alu_exec_pkg.sv | 34 +++
 rtl/alu_exec_seq_if.sv | 30 +++
 rtl/alu_exec_decode.sv | 39 +++
 rtl/alu_exec_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_exec_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - ALU control codes, funct/AluOp encodings and FSM state encoding
package alu_exec_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1011;
  localparam logic [3:0] ALU_SRL = 4'b1110;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_MUL = 6'b011000;

  localparam logic [1:0] OP_LWSW  = 2'b00;
  localparam logic [1:0] OP_BEQ   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;
  localparam logic [1:0] OP_BNE   = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_MULT  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/alu_exec_seq_if.sv
// rtl/alu_exec_seq_if.sv - request/response handshake bundle for the EX-stage ALU
interface alu_exec_seq_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic [DATA_W-1:0]  op_a;
  logic [DATA_W-1:0]  op_b;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  result;
  logic [3:0]         alu_ctrl;
  logic               zero;
  logic               branch_taken;
  logic               illegal;

  modport master (
    output in_valid, alu_op, funct, shamt, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, alu_ctrl, zero, branch_taken, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, shamt, op_a, op_b, out_ready,
    output in_ready, out_valid, result, alu_ctrl, zero, branch_taken, illegal
  );
endinterface

// File: rtl/alu_exec_decode.sv
// rtl/alu_exec_decode.sv - combinational AluOp/funct decoder, shared with hazard logic
// Multiply decode is present only with ALU_EXEC_SEQ_MULT_EN.
module alu_exec_decode
  import alu_exec_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       is_shift_o,
  output logic       is_mult_o,
  output logic       illegal_o
);
  always_comb begin
    alu_ctrl_o = ALU_AND;
    is_shift_o = 1'b0;
    is_mult_o  = 1'b0;
    illegal_o  = 1'b0;
    case (alu_op_i)
      OP_LWSW: alu_ctrl_o = ALU_ADD;
      OP_BEQ:  alu_ctrl_o = ALU_SUB;
      OP_BNE:  alu_ctrl_o = ALU_BNE;
      default: begin
        case (funct_i)
          F_ADD: alu_ctrl_o = ALU_ADD;
          F_SUB: alu_ctrl_o = ALU_SUB;
          F_AND: alu_ctrl_o = ALU_AND;
          F_OR:  alu_ctrl_o = ALU_OR;
          F_SLT: alu_ctrl_o = ALU_SLT;
          F_SLL: begin alu_ctrl_o = ALU_SLL; is_shift_o = 1'b1; end
          F_SRL: begin alu_ctrl_o = ALU_SRL; is_shift_o = 1'b1; end
`ifdef ALU_EXEC_SEQ_MULT_EN
          F_MUL: begin alu_ctrl_o = ALU_MUL; is_mult_o = 1'b1; end
`endif
          default: illegal_o = 1'b1;
        endcase
      end
    endcase
  end
endmodule

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - EX-stage ALU: single-cycle ops, bit-serial shifts, optional multiply
// Shift-add multiply is built only with ALU_EXEC_SEQ_MULT_EN.
module alu_exec_seq
  import alu_exec_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input logic           clk,
  input logic           reset,
  alu_exec_seq_if.slave bus
);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [3:0] dec_ctrl;
  logic       dec_is_shift, dec_is_mult, dec_illegal;

  alu_exec_decode u_decode (
    .alu_op_i   (bus.alu_op),
    .funct_i    (bus.funct),
    .alu_ctrl_o (dec_ctrl),
    .is_shift_o (dec_is_shift),
    .is_mult_o  (dec_is_mult),
    .illegal_o  (dec_illegal)
  );

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic [DATA_W-1:0]  work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic               zero_q, zero_d, branch_q, branch_d, illegal_q, illegal_d;
  logic               left_q, left_d;
  logic [DATA_W-1:0]  alu_now, shifted;
  logic               branch_now;
`ifdef ALU_EXEC_SEQ_MULT_EN
  logic [DATA_W-1:0]  mcand_q, mcand_d, mplier_q, mplier_d, acc;
`else
  logic               dec_mult_unused;
  assign dec_mult_unused = dec_is_mult;
`endif

  // Single-cycle result; shifts reach here only with shamt == 0, so they pass op_b.
  always_comb begin
    alu_now = '0;
    if (!dec_illegal) begin
      case (dec_ctrl)
        ALU_ADD:          alu_now = bus.op_a + bus.op_b;
        ALU_SUB, ALU_BNE: alu_now = bus.op_a - bus.op_b;
        ALU_AND:          alu_now = bus.op_a & bus.op_b;
        ALU_OR:           alu_now = bus.op_a | bus.op_b;
        ALU_SLT:          alu_now = {{(DATA_W-1){1'b0}}, $signed(bus.op_a) < $signed(bus.op_b)};
        ALU_SLL, ALU_SRL: alu_now = bus.op_b;
        default:          alu_now = '0;
      endcase
    end
  end

  assign branch_now = (bus.alu_op == OP_BEQ) ? (bus.op_a == bus.op_b) :
                      (bus.alu_op == OP_BNE) ? (bus.op_a != bus.op_b) : 1'b0;
  assign shifted    = left_q ? (work_q << 1) : (work_q >> 1);
`ifdef ALU_EXEC_SEQ_MULT_EN
  assign acc        = work_q + (mplier_q[0] ? mcand_q : '0);
`endif

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    zero_d    = zero_q;
    branch_d  = branch_q;
    illegal_d = illegal_q;
    left_d    = left_q;
`ifdef ALU_EXEC_SEQ_MULT_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          ctrl_d    = dec_ctrl;
          illegal_d = dec_illegal;
          branch_d  = branch_now;
          if (dec_is_shift && (bus.shamt != '0)) begin
            work_d  = bus.op_b;
            cnt_d   = bus.shamt;
            left_d  = (dec_ctrl == ALU_SLL);
            state_d = ST_SHIFT;
`ifdef ALU_EXEC_SEQ_MULT_EN
          end else if (dec_is_mult) begin
            work_d   = '0;
            mcand_d  = bus.op_a;
            mplier_d = bus.op_b;
            cnt_d    = '1;
            state_d  = ST_MULT;
`endif
          end else begin
            result_d = alu_now;
            zero_d   = (alu_now == '0);
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          state_d  = ST_DONE;
        end
      end
`ifdef ALU_EXEC_SEQ_MULT_EN
      // One multiplier bit per cycle; cnt runs DATA_W-1 down to 0.
      ST_MULT: begin
        work_d   = acc;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == '0) begin
          result_d = acc;
          zero_d   = (acc == '0);
          state_d  = ST_DONE;
        end
      end
`endif
      ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      ctrl_q    <= ALU_AND;
      zero_q    <= 1'b0;
      branch_q  <= 1'b0;
      illegal_q <= 1'b0;
      left_q    <= 1'b0;
`ifdef ALU_EXEC_SEQ_MULT_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      zero_q    <= zero_d;
      branch_q  <= branch_d;
      illegal_q <= illegal_d;
      left_q    <= left_d;
`ifdef ALU_EXEC_SEQ_MULT_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
`endif
    end
  end

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.out_valid    = (state_q == ST_DONE);
  assign bus.result       = result_q;
  assign bus.alu_ctrl     = ctrl_q;
  assign bus.zero         = zero_q;
  assign bus.branch_taken = branch_q;
  assign bus.illegal      = illegal_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - scoreboard bench for alu_exec_seq with a behavioural reference model
module tb_alu_exec_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_exec_seq_if #(.DATA_W(32), .SHAMT_W(5)) bus ();
  alu_exec_seq #(.DATA_W(32), .SHAMT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] result;
    logic [3:0]  ctrl;
    logic        zero;
    logic        branch;
    logic        illegal;
    int          lat;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur = 0;
  bit   chk_idle = 0;
  int   stall_n = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: results straight from the instruction semantics.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] f, input int sh,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.result = 32'h0; e.ctrl = 4'h0; e.illegal = 1'b0; e.lat = 0; e.due = 0;
    e.branch = (op == 2'b01) ? (a == b) : (op == 2'b11) ? (a != b) : 1'b0;
    case (op)
      2'b00: begin e.ctrl = 4'b0010; e.result = a + b; end
      2'b01: begin e.ctrl = 4'b0110; e.result = a - b; end
      2'b11: begin e.ctrl = 4'b1011; e.result = a - b; end
      default: begin
        case (f)
          6'b100000: begin e.ctrl = 4'b0010; e.result = a + b; end
          6'b100010: begin e.ctrl = 4'b0110; e.result = a - b; end
          6'b100100: begin e.ctrl = 4'b0000; e.result = a & b; end
          6'b100101: begin e.ctrl = 4'b0001; e.result = a | b; end
          6'b101010: begin e.ctrl = 4'b0111; e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          6'b000000: begin e.ctrl = 4'b1111; e.result = b << sh; e.lat = sh; end
          6'b000010: begin e.ctrl = 4'b1110; e.result = b >> sh; e.lat = sh; end
`ifdef ALU_EXEC_SEQ_MULT_EN
          6'b011000: begin e.ctrl = 4'b1000; e.result = a * b; e.lat = 32; end
`endif
          default: e.illegal = 1'b1;
        endcase
      end
    endcase
    e.zero = (e.result == 32'h0);
    return e;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [5:0] f, input int sh,
                       input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 300) begin @(negedge clk); w++; end
    if (w >= 300) begin chk("issue_timeout", 64'd0, 64'd1); return; end
    bus.alu_op = op; bus.funct = f; bus.shamt = sh[4:0]; bus.op_a = a; bus.op_b = b;
    bus.in_valid = 1'b1;
    e = model(op, f, sh, a, b);
    @(posedge clk); #1;
    e.due = cyc + e.lat;
    exp_q.push_back(e);
    bus.in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      have_cur = 0;
      chk_idle = 0;
      bus.out_ready = 1'b0;
    end else begin
      if (chk_idle) begin
        chk("idle_after_handshake", {62'd0, bus.in_ready, bus.out_valid}, 64'h2);
        chk_idle = 0;
      end
      if (bus.out_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'd1, 64'd0);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            chk("latency", cyc, cur.due);
          end
        end
        if (have_cur) begin
          chk("result", bus.result, cur.result);
          chk("alu_ctrl", bus.alu_ctrl, cur.ctrl);
          chk("flags", {61'd0, bus.zero, bus.branch_taken, bus.illegal},
              {61'd0, cur.zero, cur.branch, cur.illegal});
        end
        chk("in_ready_in_done", bus.in_ready, 64'd0);
        if (stall_n > 0) begin
          bus.out_ready = 1'b0;
          stall_n--;
        end else begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        if (bus.out_ready) begin
          have_cur = 0;
          chk_idle = 1;
        end
      end else begin
        bus.out_ready = 1'b0;
      end
    end
  end

  initial begin
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] a, b;
    logic [5:0]  fl [9];
    int          sh, w;
    fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
           6'b000000, 6'b000010, 6'b011000, 6'b111111};
    bus.in_valid = 1'b0; bus.alu_op = 2'b00; bus.funct = 6'b0; bus.shamt = 5'd0;
    bus.op_a = 32'h0; bus.op_b = 32'h0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", bus.out_valid, 64'd0);
    chk("reset_result", bus.result, 64'd0);
    chk("reset_ctrl_flags", {bus.alu_ctrl, bus.zero, bus.branch_taken, bus.illegal}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", bus.in_ready, 64'd1);

    issue(2'b10, 6'b100000, 0, 32'd5, 32'd7);
    issue(2'b10, 6'b000000, 4, 32'd0, 32'h1);
    repeat (4) begin
      @(negedge clk);
      chk("busy_in_ready", {62'd0, bus.in_ready, bus.out_valid}, 64'd0);
    end
    issue(2'b10, 6'b000010, 31, 32'd0, 32'h8000_0000);
    issue(2'b10, 6'b000010, 0, 32'd0, 32'hDEAD_BEEF);
    issue(2'b11, 6'b000000, 0, 32'd9, 32'd9);
    issue(2'b01, 6'b000000, 0, 32'd9, 32'd9);
    stall_n = 10;
    issue(2'b10, 6'b100101, 0, 32'hF0, 32'h0F);
    issue(2'b10, 6'b111111, 0, 32'h12, 32'h34);
    issue(2'b10, 6'b101010, 0, 32'hFFFF_FFFF, 32'd1);

    w = 0;
    while ((exp_q.size() != 0 || have_cur) && w < 500) begin @(negedge clk); w++; end
    issue(2'b10, 6'b000000, 8, 32'h3, 32'h5);
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b1; #1;
    chk("midshift_reset_out_valid", bus.out_valid, 64'd0);
    chk("midshift_reset_result", bus.result, 64'd0);
    chk("midshift_reset_ctrl", bus.alu_ctrl, 64'd0);
    exp_q.delete();
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", bus.in_ready, 64'd1);

    for (int i = 0; i < 120; i++) begin
      op = 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fl[$urandom_range(0, 8)];
      case ($urandom_range(0, 5))
        0: sh = 0;
        1: sh = 31;
        default: sh = $urandom_range(0, 31);
      endcase
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      if ($urandom_range(0, 9) == 0) stall_n = $urandom_range(1, 6);
      issue(op, f, sh, a, b);
    end

    w = 0;
    while ((exp_q.size() != 0 || have_cur) && w < 500) begin @(negedge clk); w++; end
    if (w >= 500) chk("drain_timeout", 64'd0, 64'd1);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
